turtle_contact_detector: RTL and testbench



---
 rtl/turtle_contact_detector_if.sv | 30 +++
 rtl/turtle_contact_detector.sv | 121 ++++++++++++
 tb/tb_turtle_contact_detector.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/turtle_contact_detector_if.sv
// Bundle between the Mario/turtle position sources and the contact detector.
// Carries the per-frame sample inputs and the four one-cycle outcome pulses.
// master drives positions and flags; slave (the detector) drives the pulses.
interface turtle_contact_detector_if;
  logic        frame_tick;
  logic [10:0] mario_x;
  logic [10:0] mario_y;
  logic        mario_falling;
  logic [10:0] turtle_w;
  logic [10:0] turtle_h;
  logic        turtle_active;
  logic        turtle_shell;
  logic        turtle_shell_moving;
  logic        press_impulse;
  logic        collapsion_impulse;
  logic        mario_bounce;
  logic        mario_hurt;

  modport master (
    output frame_tick, mario_x, mario_y, mario_falling,
           turtle_w, turtle_h, turtle_active, turtle_shell, turtle_shell_moving,
    input  press_impulse, collapsion_impulse, mario_bounce, mario_hurt
  );

  modport slave (
    input  frame_tick, mario_x, mario_y, mario_falling,
           turtle_w, turtle_h, turtle_active, turtle_shell, turtle_shell_moving,
    output press_impulse, collapsion_impulse, mario_bounce, mario_hurt
  );
endinterface

// File: rtl/turtle_contact_detector.sv
// Per-frame Mario/turtle box contact detector producing stomp/kick/hurt/bounce pulses.
// Latency: 1 clk from the sampling frame_tick to the registered output pulse.
// No backpressure: pulses are fire-and-forget; a cooldown/contact FSM makes one contact yield one event.
module turtle_contact_detector #(
  parameter int MARIO_W      = 16,
  parameter int MARIO_H      = 16,
  parameter int TURTLE_W     = 16,
  parameter int TURTLE_H     = 24,
  parameter int STOMP_MARGIN = 6,
  parameter int COOLDOWN     = 8
) (
  input  logic                         clk,
  input  logic                         rstn,   // active-high synchronous reset
  turtle_contact_detector_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COOLDOWN = 2'd1,
    S_CONTACT  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_press, r_coll, r_bounce, r_hurt;
  logic        w_press_nxt, w_coll_nxt, w_bounce_nxt, w_hurt_nxt;

  // 12-bit sums so boxes near the 2047 screen limit never wrap
  logic [11:0] w_mario_x, w_mario_y, w_turtle_x, w_turtle_y;
  logic [11:0] w_mario_r, w_mario_b, w_turtle_r, w_turtle_b, w_stomp_lim;
  logic        w_overlap, w_stomp;

  assign w_mario_x   = {1'b0, bus.mario_x};
  assign w_mario_y   = {1'b0, bus.mario_y};
  assign w_turtle_x  = {1'b0, bus.turtle_w};
  assign w_turtle_y  = {1'b0, bus.turtle_h};
  assign w_mario_r   = w_mario_x  + 12'(MARIO_W);
  assign w_mario_b   = w_mario_y  + 12'(MARIO_H);
  assign w_turtle_r  = w_turtle_x + 12'(TURTLE_W);
  assign w_turtle_b  = w_turtle_y + 12'(TURTLE_H);
  assign w_stomp_lim = w_turtle_y + 12'(STOMP_MARGIN);

  // Strict comparisons: boxes that only share an edge do not touch
  assign w_overlap = (w_mario_x < w_turtle_r) && (w_turtle_x < w_mario_r) &&
                     (w_mario_y < w_turtle_b) && (w_turtle_y < w_mario_b);
  assign w_stomp   = bus.mario_falling && (w_mario_b <= w_stomp_lim);

  // Next-state, counter and pulse decode; everything only moves on frame_tick
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_press_nxt  = 1'b0;
    w_coll_nxt   = 1'b0;
    w_bounce_nxt = 1'b0;
    w_hurt_nxt   = 1'b0;
    if (bus.frame_tick) begin
      if (!bus.turtle_active) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_overlap) begin
              w_state_nxt = S_COOLDOWN;
              w_cnt_nxt   = 4'(COOLDOWN);
              if (w_stomp) begin
                w_press_nxt  = 1'b1;
                w_bounce_nxt = 1'b1;
              end else if (bus.turtle_shell && !bus.turtle_shell_moving) begin
                w_coll_nxt   = 1'b1;
              end else begin
                w_hurt_nxt   = 1'b1;
              end
            end
          end
          S_COOLDOWN: begin
            // The tick that brings the counter to zero also decides where to go
            if (r_cnt <= 4'd1) begin
              w_cnt_nxt   = 4'd0;
              w_state_nxt = w_overlap ? S_CONTACT : S_IDLE;
            end else begin
              w_cnt_nxt   = r_cnt - 4'd1;
            end
          end
          S_CONTACT: begin
            if (!w_overlap) w_state_nxt = S_IDLE;
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
          end
        endcase
      end
    end
  end

  // State, counter and output pulse registers; reset wins over a coincident tick
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_press  <= 1'b0;
      r_coll   <= 1'b0;
      r_bounce <= 1'b0;
      r_hurt   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_press  <= w_press_nxt;
      r_coll   <= w_coll_nxt;
      r_bounce <= w_bounce_nxt;
      r_hurt   <= w_hurt_nxt;
    end
  end

  assign bus.press_impulse      = r_press;
  assign bus.collapsion_impulse = r_coll;
  assign bus.mario_bounce       = r_bounce;
  assign bus.mario_hurt         = r_hurt;

endmodule

// File: tb/tb_turtle_contact_detector.sv
// Directed bench for turtle_contact_detector with a frame-level reference model.
// Outputs are checked every cycle against the model and at key points against literals.
// Output vector order everywhere: {press, collapsion, bounce, hurt}.
module tb_turtle_contact_detector;
  logic clk;
  logic rstn;
  int   n_asserts;
  int   n_fail;
  bit   cmp_en;

  turtle_contact_detector_if bus();

  turtle_contact_detector dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] dut_out;
  assign dut_out = {bus.press_impulse, bus.collapsion_impulse, bus.mario_bounce, bus.mario_hurt};

  // Reference model: frames of cooldown left and whether Mario is still touching
  int         cd_left;
  bit         touching;
  logic [3:0] exp_out;

  function automatic bit boxes_overlap();
    int mx, my, tx, ty;
    mx = int'(bus.mario_x);  my = int'(bus.mario_y);
    tx = int'(bus.turtle_w); ty = int'(bus.turtle_h);
    return (mx < tx + 16) && (tx < mx + 16) && (my < ty + 24) && (ty < my + 16);
  endfunction

  initial begin
    cd_left  = 0;
    touching = 0;
    exp_out  = 4'b0000;
  end

  always @(posedge clk) begin
    bit ov;
    exp_out = 4'b0000;
    if (rstn) begin
      cd_left  = 0;
      touching = 0;
    end else if (bus.frame_tick) begin
      ov = boxes_overlap();
      if (!bus.turtle_active) begin
        cd_left  = 0;
        touching = 0;
      end else if (cd_left > 0) begin
        cd_left = cd_left - 1;
        if (cd_left == 0) touching = ov;
      end else if (touching) begin
        touching = ov;
      end else if (ov) begin
        if (bus.mario_falling && (int'(bus.mario_y) + 16 <= int'(bus.turtle_h) + 6))
          exp_out = 4'b1010;
        else if (bus.turtle_shell && !bus.turtle_shell_moving)
          exp_out = 4'b0100;
        else
          exp_out = 4'b0001;
        cd_left = 8;
      end
    end
  end

  // Per-cycle comparison of DUT against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      n_asserts++;
      if (dut_out !== exp_out) begin
        n_fail++;
        $display("FAIL model_cycle t=%0t got=%b expected=%b", $time, dut_out, exp_out);
      end
    end
  end

  task automatic check_lit(input logic [3:0] want, input string name);
    n_asserts++;
    if (dut_out !== want) begin
      n_fail++;
      $display("FAIL %s got=%b expected=%b", name, dut_out, want);
    end
  endtask

  // One frame_tick, then check the pulse in the following cycle
  task automatic do_tick(input logic [3:0] want, input string name);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    check_lit(want, name);
  endtask

  task automatic set_pos(input int mx, input int my, input int tx, input int ty);
    bus.mario_x  = 11'(mx);
    bus.mario_y  = 11'(my);
    bus.turtle_w = 11'(tx);
    bus.turtle_h = 11'(ty);
  endtask

  // Separate long enough to exhaust any cooldown and leave contact
  task automatic settle();
    set_pos(500, 500, 100, 200);
    for (int i = 0; i < 10; i++) do_tick(4'b0000, "settle");
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    cmp_en    = 1'b0;
    rstn      = 1'b1;
    bus.frame_tick          = 1'b0;
    bus.mario_falling       = 1'b0;
    bus.turtle_active       = 1'b1;
    bus.turtle_shell        = 1'b0;
    bus.turtle_shell_moving = 1'b0;
    set_pos(500, 500, 100, 200);

    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check_lit(4'b0000, "reset_state");
    rstn = 1'b0;

    // Stomp
    set_pos(100, 186, 100, 200);
    bus.mario_falling = 1'b1;
    do_tick(4'b1010, "stomp");
    @(negedge clk);
    check_lit(4'b0000, "stomp_one_cycle");
    settle();

    // Side contact with walking turtle
    set_pos(90, 200, 100, 200);
    bus.mario_falling = 1'b0;
    do_tick(4'b0001, "side_hurt");
    settle();

    // Kick idle shell, then moving shell hurts
    bus.turtle_shell = 1'b1;
    set_pos(90, 200, 100, 200);
    do_tick(4'b0100, "kick");
    settle();
    bus.turtle_shell_moving = 1'b1;
    set_pos(90, 200, 100, 200);
    do_tick(4'b0001, "moving_shell_hurt");
    settle();
    bus.turtle_shell        = 1'b0;
    bus.turtle_shell_moving = 1'b0;

    // Held stomp overlap for 12 ticks gives exactly one event
    bus.mario_falling = 1'b1;
    set_pos(100, 186, 100, 200);
    do_tick(4'b1010, "hold_first");
    for (int i = 2; i <= 12; i++) do_tick(4'b0000, "hold_quiet");
    set_pos(200, 186, 100, 200);
    do_tick(4'b0000, "separate");
    set_pos(100, 186, 100, 200);
    do_tick(4'b1010, "reoverlap");
    settle();

    // Boundaries
    set_pos(84, 200, 100, 200);
    bus.mario_falling = 1'b0;
    do_tick(4'b0000, "edge_touch");
    bus.mario_falling = 1'b1;
    set_pos(100, 187, 100, 200);
    do_tick(4'b1010, "stomp_margin_in");
    settle();
    set_pos(100, 191, 100, 200);
    do_tick(4'b0001, "stomp_margin_out");
    settle();
    bus.mario_falling = 1'b0;
    set_pos(2040, 200, 2040, 200);
    do_tick(4'b0001, "no_wrap");
    settle();

    // Reset during cooldown, coincident with a tick
    bus.mario_falling = 1'b1;
    set_pos(100, 186, 100, 200);
    do_tick(4'b1010, "pre_reset_stomp");
    do_tick(4'b0000, "cooldown_1");
    do_tick(4'b0000, "cooldown_2");
    @(negedge clk);
    rstn = 1'b1;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    bus.frame_tick = 1'b0;
    check_lit(4'b0000, "reset_wins");
    do_tick(4'b1010, "post_reset_stomp");

    // Inactive turtle mid-cooldown: no outputs, and the cooldown is cleared
    bus.turtle_active = 1'b0;
    do_tick(4'b0000, "inactive");
    bus.turtle_active = 1'b1;
    do_tick(4'b1010, "reactivated");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
